// File: rtl/cmd_pkg.sv
// ============================================================================
//  Module   : cmd_pkg
//  Purpose  : Shared definitions for the command-frame path: FSM state
//             encoding, CRC-8 initial value and the default CRC polynomial.
//             Also imported by the host-side frame builder.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

package cmd_pkg;

    // Receiver FSM: IDLE holds no bytes, COLLECT holds 1..FRAME_BYTES-1 bytes.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    localparam logic [7:0] c_CRC_INIT         = 8'h00;
    localparam logic [7:0] c_CRC_POLY_DEFAULT = 8'h07;

endpackage : cmd_pkg

`default_nettype wire

// File: rtl/crc8_byte.sv
// ============================================================================
//  Module   : crc8_byte
//  Purpose  : Combinational CRC-8 update over one byte, MSB-first,
//             no reflection, no final XOR.
//  Ports    : crc_in  - running CRC before this byte
//             data    - byte to fold in
//             poly    - generator polynomial (implicit x^8 term)
//             crc_out - running CRC after this byte
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

module crc8_byte (
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    input  logic [7:0] poly,
    output logic [7:0] crc_out
);

    logic [7:0] w_crc;

    always_comb begin
        w_crc = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            if (w_crc[7]) begin
                w_crc = {w_crc[6:0], 1'b0} ^ poly;
            end else begin
                w_crc = {w_crc[6:0], 1'b0};
            end
        end
        crc_out = w_crc;
    end

endmodule : crc8_byte

`default_nettype wire

// File: rtl/cmd_frame_assembler.sv
// ============================================================================
//  Module   : cmd_frame_assembler
//  Purpose  : Assembles toggle-qualified bytes into fixed-length command
//             frames, checks the trailing CRC-8 byte and discards partial
//             frames that stall for TIMEOUT_CYCLES.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             en                - accept enable
//             in_byte           - data byte, valid when byte_finished toggles
//             byte_finished     - toggle strobe, one level change per byte
//             crc_en            - CRC check enable (crc_ok forced 1 when low)
//             frame, cmd, crc   - last completed frame and its first/last byte
//             crc_ok            - CRC verdict of the last completed frame
//             frame_finished    - toggles once per completed frame
//             frame_valid       - one-cycle pulse per completed frame
//             timeout           - one-cycle pulse when a partial is discarded
//             byte_index        - bytes held in the partial frame
//             crc_err_cnt       - saturating count of CRC failures
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

module cmd_frame_assembler
    import cmd_pkg::*;
#(
    parameter int          FRAME_BYTES    = 4,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  CRC_POLY       = c_CRC_POLY_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [7:0]                 in_byte,
    input  logic                       byte_finished,
    input  logic                       crc_en,
    output logic [FRAME_BYTES*8-1:0]   frame,
    output logic [7:0]                 cmd,
    output logic [7:0]                 crc,
    output logic                       crc_ok,
    output logic                       frame_finished,
    output logic                       frame_valid,
    output logic                       timeout,
    output logic [2:0]                 byte_index,
    output logic [7:0]                 crc_err_cnt
);

    localparam int              c_SHADOW_N  = FRAME_BYTES - 1;
    localparam int              c_TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int              c_TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(c_TO_LAST_I);
    localparam bit              c_TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [2:0]      c_LAST_IDX  = 3'(FRAME_BYTES - 1);

    state_t                     r_state;
    logic [2:0]                 r_byte_index;
    logic [7:0]                 r_crc;
    logic [7:0]                 r_shadow [c_SHADOW_N];
    logic [FRAME_BYTES*8-1:0]   r_frame;
    logic                       r_crc_ok;
    logic                       r_frame_finished;
    logic                       r_frame_valid;
    logic                       r_timeout;
    logic [7:0]                 r_crc_err_cnt;
    logic [c_TW-1:0]            r_to_cnt;
    logic                       r_prev_finished;

    logic                       w_byte_evt;
    logic                       w_last;
    logic                       w_to_expire;
    logic                       w_crc_match;
    logic [7:0]                 w_crc_next;
    logic [FRAME_BYTES*8-1:0]   w_frame_next;

    // Toggles seen while en=0 are absorbed because r_prev_finished keeps
    // tracking byte_finished regardless of en.
    assign w_byte_evt  = en && (byte_finished != r_prev_finished);
    assign w_last      = (r_byte_index == c_LAST_IDX);
    // A byte event on the expiry cycle takes priority over the timeout.
    assign w_to_expire = c_TO_EN && (r_state == ST_COLLECT) && en && !w_byte_evt
                         && (r_to_cnt == c_TO_LAST);
    assign w_crc_match = (r_crc == in_byte) || !crc_en;

    crc8_byte u_crc8 (
        .crc_in  (r_crc),
        .data    (in_byte),
        .poly    (CRC_POLY),
        .crc_out (w_crc_next)
    );

    // Completed frame: shadow byte 0 lands in the MSBs, the live CRC byte in the LSBs.
    always_comb begin
        w_frame_next = '0;
        for (int i = 0; i < c_SHADOW_N; i++) begin
            w_frame_next[(FRAME_BYTES-1-i)*8 +: 8] = r_shadow[i];
        end
        w_frame_next[7:0] = in_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_byte_index     <= '0;
            r_crc            <= c_CRC_INIT;
            for (int i = 0; i < c_SHADOW_N; i++) begin
                r_shadow[i] <= '0;
            end
            r_frame          <= '0;
            r_crc_ok         <= 1'b0;
            r_frame_finished <= 1'b0;
            r_frame_valid    <= 1'b0;
            r_timeout        <= 1'b0;
            r_crc_err_cnt    <= '0;
            r_to_cnt         <= '0;
            r_prev_finished  <= byte_finished;
        end else begin
            r_prev_finished <= byte_finished;
            r_frame_valid   <= 1'b0;
            r_timeout       <= 1'b0;

            // Non-final bytes go to the slot addressed by the current index.
            if (w_byte_evt && !w_last) begin
                for (int i = 0; i < c_SHADOW_N; i++) begin
                    if (r_byte_index == 3'(i)) begin
                        r_shadow[i] <= in_byte;
                    end
                end
            end

            case (r_state)
                ST_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_byte_evt) begin
                        r_crc        <= w_crc_next;
                        r_byte_index <= 3'd1;
                        r_state      <= ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    if (w_byte_evt) begin
                        r_to_cnt <= '0;
                        if (w_last) begin
                            r_frame          <= w_frame_next;
                            r_crc_ok         <= w_crc_match;
                            r_frame_finished <= ~r_frame_finished;
                            r_frame_valid    <= 1'b1;
                            if (!w_crc_match && (r_crc_err_cnt != 8'hFF)) begin
                                r_crc_err_cnt <= r_crc_err_cnt + 8'd1;
                            end
                            r_crc        <= c_CRC_INIT;
                            r_byte_index <= '0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_crc        <= w_crc_next;
                            r_byte_index <= r_byte_index + 3'd1;
                        end
                    end else if (w_to_expire) begin
                        r_crc        <= c_CRC_INIT;
                        r_byte_index <= '0;
                        r_to_cnt     <= '0;
                        r_timeout    <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else if (en && c_TO_EN) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign frame          = r_frame;
    assign cmd            = r_frame[FRAME_BYTES*8-1 -: 8];
    assign crc            = r_frame[7:0];
    assign crc_ok         = r_crc_ok;
    assign frame_finished = r_frame_finished;
    assign frame_valid    = r_frame_valid;
    assign timeout        = r_timeout;
    assign byte_index     = r_byte_index;
    assign crc_err_cnt    = r_crc_err_cnt;

endmodule : cmd_frame_assembler

`default_nettype wire
